// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types for the hazard scoreboard
package rf_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int ENTRY_W  = REG_W + 1;

  // "reg" is a keyword, so the destination field is named rd
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - hit detection of one register index against the shadow pipeline
module sb_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic [DEPTH*ENTRY_W-1:0] entries,
  input  logic [REG_W-1:0]         idx,
  input  logic                     excl_wb,
  output logic                     hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(excl_wb && (i == DEPTH - 1)) &&
          entries[i*ENTRY_W + REG_W] &&
          (entries[i*ENTRY_W +: REG_W] == idx)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_hazard_scoreboard.sv
// rtl/rf_hazard_scoreboard.sv - decode-side RAW stall and writeback cross-check for the 8x16b RF
module rf_hazard_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH       = 3,
  parameter int BYPASS      = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       issue_wr_en,
  input  logic [2:0] issue_wr_reg,
  input  logic       rs_used,
  input  logic [2:0] rs_reg,
  input  logic       rt_used,
  input  logic [2:0] rt_reg,
  input  logic       advance,
  input  logic       flush,
  input  logic       wb_wr_en,
  input  logic [2:0] wb_reg,
  output logic       stall,
  output logic       rf_bypass_dis,
  output logic [7:0] pending,
  output logic       err
);

  // entry[0] is EX, entry[DEPTH-1] is WB
  sb_entry_t [DEPTH-1:0]     ent;
  logic [DEPTH*ENTRY_W-1:0] ent_flat;
  logic                     excl_wb;
  logic                     rs_hit;
  logic                     rt_hit;
  logic                     hazard;
  logic                     issue;
  logic                     wb_mismatch;

  assign ent_flat      = ent;
  assign excl_wb       = (BYPASS != 0);
  assign rf_bypass_dis = (BYPASS != 0) ? 1'b0 : 1'b1;

  sb_match #(.DEPTH(DEPTH)) u_rs_match (
    .entries (ent_flat),
    .idx     (rs_reg),
    .excl_wb (excl_wb),
    .hit     (rs_hit)
  );

  sb_match #(.DEPTH(DEPTH)) u_rt_match (
    .entries (ent_flat),
    .idx     (rt_reg),
    .excl_wb (excl_wb),
    .hit     (rt_hit)
  );

  assign hazard = (rs_used & rs_hit) | (rt_used & rt_hit);
  assign stall  = issue_valid & (hazard | ~advance);
  assign issue  = issue_valid & ~stall & ~flush;

  assign wb_mismatch = (wb_wr_en != ent[DEPTH-1].v) |
                       (ent[DEPTH-1].v & (wb_reg != ent[DEPTH-1].rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
      err <= 1'b0;
    end else begin
      if (advance) begin
        ent[0].v  <= issue & issue_wr_en;
        ent[0].rd <= issue_wr_reg;
        for (int i = 1; i < DEPTH; i++) begin
          ent[i] <= ent[i-1];
        end
        if (wb_mismatch) begin
          err <= 1'b1;
        end
      end
      // later assignment wins over the shift, killing the youngest entries
      if (flush) begin
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
          ent[i].v <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (ent[i].v && (ent[i].rd == REG_W'(r))) begin
          pending[r] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// tb/tb_rf_hazard_scoreboard.sv - scoreboard bench for rf_hazard_scoreboard
module tb_rf_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wr_en, rs_used, rt_used, advance, flush, wb_wr_en;
  logic [2:0] issue_wr_reg, rs_reg, rt_reg, wb_reg;
  logic       stall, rf_bypass_dis, err;
  logic [7:0] pending;
  logic       stall_nb, rf_bypass_dis_nb, err_nb;
  logic [7:0] pending_nb;

  always #5 clk = ~clk;

  rf_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_wr_reg(issue_wr_reg), .rs_used(rs_used), .rs_reg(rs_reg),
    .rt_used(rt_used), .rt_reg(rt_reg), .advance(advance), .flush(flush),
    .wb_wr_en(wb_wr_en), .wb_reg(wb_reg), .stall(stall),
    .rf_bypass_dis(rf_bypass_dis), .pending(pending), .err(err)
  );

  rf_hazard_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_wr_reg(issue_wr_reg), .rs_used(rs_used), .rs_reg(rs_reg),
    .rt_used(rt_used), .rt_reg(rt_reg), .advance(advance), .flush(flush),
    .wb_wr_en(wb_wr_en), .wb_reg(wb_reg), .stall(stall_nb),
    .rf_bypass_dis(rf_bypass_dis_nb), .pending(pending_nb), .err(err_nb)
  );

  typedef struct {
    string      name;
    logic       stall;
    logic [7:0] pend;
    logic       err;
    logic       chk_nb;
    logic       stall_nb;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // expected WB occupant, used only to drive matching writeback stimulus
  logic       sh_v[3];
  logic [2:0] sh_r[3];
  logic       wb_ovr = 1'b0;
  logic       wb_ovr_en = 1'b0;
  logic [2:0] wb_ovr_reg = 3'd0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, " stall"}, {7'd0, stall}, {7'd0, e.stall});
      cmp({e.name, " pending"}, pending, e.pend);
      cmp({e.name, " err"}, {7'd0, err}, {7'd0, e.err});
      cmp({e.name, " bypass_dis"}, {7'd0, rf_bypass_dis}, 8'd0);
      cmp({e.name, " bypass_dis_nb"}, {7'd0, rf_bypass_dis_nb}, 8'd1);
      if (e.chk_nb) begin
        cmp({e.name, " stall_nb"}, {7'd0, stall_nb}, {7'd0, e.stall_nb});
        cmp({e.name, " pending_nb"}, pending_nb, e.pend);
        cmp({e.name, " err_nb"}, {7'd0, err_nb}, {7'd0, e.err});
      end
    end
  end

  task automatic clr_shadow();
    for (int i = 0; i < 3; i++) begin
      sh_v[i] = 1'b0;
      sh_r[i] = 3'd0;
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_wr_en = 0; issue_wr_reg = 0;
    rs_used = 0; rs_reg = 0; rt_used = 0; rt_reg = 0;
    advance = 1; flush = 0; wb_wr_en = 0; wb_reg = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_shadow();
  endtask

  task automatic step(input string nm, input logic v, input logic we, input logic [2:0] wr,
                      input logic ru, input logic [2:0] rs, input logic tu, input logic [2:0] rt,
                      input logic adv, input logic fl, input logic es, input logic [7:0] ep,
                      input logic ee, input logic cnb, input logic esnb);
    exp_t e;
    logic iss;
    issue_valid = v; issue_wr_en = we; issue_wr_reg = wr;
    rs_used = ru; rs_reg = rs; rt_used = tu; rt_reg = rt;
    advance = adv; flush = fl;
    wb_wr_en = wb_ovr ? wb_ovr_en : sh_v[2];
    wb_reg   = wb_ovr ? wb_ovr_reg : sh_r[2];
    e.name = nm; e.stall = es; e.pend = ep; e.err = ee; e.chk_nb = cnb; e.stall_nb = esnb;
    q.push_back(e);
    @(posedge clk);
    iss = v & ~es & ~fl;
    if (adv) begin
      sh_v[2] = sh_v[1]; sh_r[2] = sh_r[1];
      sh_v[1] = sh_v[0]; sh_r[1] = sh_r[0];
      sh_v[0] = iss & we; sh_r[0] = wr;
    end
    if (fl) begin
      sh_v[0] = 1'b0;
      sh_v[1] = 1'b0;
    end
    wb_ovr = 1'b0;
    #1;
  endtask

  initial begin
    clr_shadow();
    do_reset();
    //    name      v we wr ru rs tu rt adv fl  stall pend   err nb snb
    step("idle",    0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);

    step("raw_c0",  1, 1, 3, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);
    step("raw_c1",  1, 0, 0, 1, 3, 0, 0, 1, 0,  1, 8'h08, 0, 1, 1);
    step("raw_c2",  1, 0, 0, 1, 3, 0, 0, 1, 0,  1, 8'h08, 0, 1, 1);
    step("raw_c3",  1, 0, 0, 1, 3, 0, 0, 1, 0,  0, 8'h08, 0, 1, 1);
    step("raw_c4",  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);

    step("adv_d0",  1, 1, 5, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);
    step("adv_d1",  1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h20, 0, 1, 1);
    step("adv_d2",  1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h20, 0, 1, 1);
    step("adv_d3",  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h20, 0, 1, 0);
    step("adv_d4",  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h20, 0, 1, 0);
    step("adv_d5",  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h20, 0, 1, 0);
    step("adv_d6",  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);

    // bogus writeback while the pipe is frozen must not flag
    wb_ovr = 1'b1; wb_ovr_en = 1'b1; wb_ovr_reg = 3'd0;
    step("skip_x0", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 1, 0);
    step("skip_x1", 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);

    step("fl_f0",   1, 1, 1, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);
    step("fl_f1",   1, 1, 2, 0, 0, 0, 0, 1, 0,  0, 8'h02, 0, 1, 0);
    step("fl_f2",   1, 1, 4, 0, 0, 0, 0, 1, 1,  0, 8'h06, 0, 1, 0);
    step("fl_f3",   1, 0, 0, 1, 2, 0, 0, 1, 0,  0, 8'h02, 0, 1, 0);
    step("fl_f4",   0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);

    step("mm_m0",   1, 1, 6, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);
    step("mm_m1",   0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h40, 0, 1, 0);
    step("mm_m2",   0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h40, 0, 1, 0);
    wb_ovr = 1'b1; wb_ovr_en = 1'b1; wb_ovr_reg = 3'd7;
    step("mm_m3",   0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h40, 0, 1, 0);
    step("mm_m4",   0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 1, 1, 0);
    step("mm_m5",   1, 1, 7, 0, 0, 0, 0, 1, 0,  0, 8'h00, 1, 1, 0);

    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_shadow();
    step("rst_r0",  0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);

    step("dual_s0", 1, 1, 2, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 1, 0);
    step("dual_s1", 1, 1, 2, 0, 0, 0, 0, 1, 0,  0, 8'h04, 0, 1, 0);
    step("dual_s2", 1, 0, 0, 0, 2, 0, 2, 1, 0,  0, 8'h04, 0, 1, 0);
    step("dual_s3", 1, 0, 0, 1, 2, 1, 2, 1, 0,  1, 8'h04, 0, 1, 1);
    step("dual_s4", 1, 1, 2, 0, 0, 1, 2, 1, 0,  0, 8'h04, 0, 1, 1);
    step("dual_s5", 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h04, 0, 0, 0);
    step("dual_s6", 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h04, 0, 0, 0);
    step("dual_s7", 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h04, 0, 0, 0);
    step("dual_s8", 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
